// File: rtl/fifo_pkg.sv
// Shared sizing helpers and constants for the parametrised sync FIFO.
// Pointer/count width helpers, reset-busy length and a power-of-two check.
package fifo_pkg;

    localparam int RST_BUSY_CYC = 1;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, synchronous write, registered read.
// Read register clears on srst; array contents are never cleared.
module fifo_sdp_ram #(
    parameter int DATA_W = 89,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store on an accepted write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: register the addressed word on an accepted read, hold otherwise
    always_ff @(posedge clk) begin
        if (srst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_param_fifo.sv
// Single-clock FIFO with registered output, occupancy count and prog_full.
// Optional sticky overflow/underflow ports under SYNC_FIFO_ERR_FLAGS_EN.
module sync_param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W       = 89,
    parameter int DEPTH        = 8,
    parameter int PROG_FULL_TH = 3,
    parameter int ADDR_W       = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              prog_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              wr_rst_busy,
    output logic              rd_rst_busy
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int  CW       = cnt_w(DEPTH);
    localparam bit  DEPTH_OK = is_pow2(DEPTH);
    localparam int  BW       = $clog2(RST_BUSY_CYC + 1);

    if (!DEPTH_OK) begin : g_bad_depth
        $error("sync_param_fifo: DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [BW-1:0]     busy_cnt;
    logic              rst_busy;
    logic              wr_acc;
    logic              rd_acc;

    assign rst_busy    = srst | (busy_cnt != '0);
    assign wr_rst_busy = rst_busy;
    assign rd_rst_busy = rst_busy;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign prog_full = (count >= CW'(PROG_FULL_TH));

    assign wr_acc = wr_en & ~full  & ~rst_busy;
    assign rd_acc = rd_en & ~empty & ~rst_busy;

    // Reset-busy window: loaded by srst, counts down after release
    always_ff @(posedge clk) begin
        if (srst)                busy_cnt <= BW'(RST_BUSY_CYC);
        else if (busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);
    end

    // Pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Occupancy: both accepted leaves it unchanged
    always_ff @(posedge clk) begin
        if (srst) begin
            count <= '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output strobe marks the cycle after an accepted read
    always_ff @(posedge clk) begin
        if (srst) valid <= 1'b0;
        else      valid <= rd_acc;
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .srst  (srst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (dout)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by srst
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Flag illegal requests in simulation
    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (!(wr_en && full))
                else $warning("sync_param_fifo: write while full");
            assert (!(rd_en && empty))
                else $warning("sync_param_fifo: read while empty");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sync_param_fifo.sv
// Scoreboard bench for sync_param_fifo with DEPTH=8, PROG_FULL_TH=3.
// Stimulus pushes expected read data; a monitor pops on every valid.
module tb_sync_param_fifo;

    localparam int DW    = 89;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full, prog_full, valid, empty;
    logic [DW-1:0] dout;
    logic [AW:0]   count;
    logic          wr_rst_busy, rd_rst_busy;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    sync_param_fifo #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .PROG_FULL_TH (3)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .prog_full   (prog_full),
        .rd_en       (rd_en),
        .dout        (dout),
        .valid       (valid),
        .empty       (empty),
        .count       (count),
        .wr_rst_busy (wr_rst_busy),
        .rd_rst_busy (rd_rst_busy)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mq [$];
    bit            m_busy = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // One clock of stimulus; the reference queue decides what is accepted
    task automatic step(input bit sr, input bit we, input logic [31:0] d,
                        input bit re);
        bit wa;
        bit ra;
        srst  = sr;
        wr_en = we;
        din   = DW'(d);
        rd_en = re;
        wa = we && !sr && !m_busy && (mq.size() < DEPTH);
        ra = re && !sr && !m_busy && (mq.size() > 0);
        if (sr) begin
            mq.delete();
        end else begin
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(DW'(d));
        end
        m_busy = sr;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Monitor: every valid must match the oldest expected word
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_valid: dout %0h, nothing expected", dout);
                end else begin
                    chk("rd_data", 128'(dout), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (3) step(1, 0, 0, 0);
        chk("rst_wr_busy", 128'(wr_rst_busy), 1);
        chk("rst_rd_busy", 128'(rd_rst_busy), 1);
        chk("rst_empty",   128'(empty), 1);
        chk("rst_full",    128'(full), 0);
        chk("rst_pfull",   128'(prog_full), 0);
        chk("rst_count",   128'(count), 0);
        chk("rst_valid",   128'(valid), 0);

        srst  = 1'b0;
        wr_en = 1'b1;
        din   = DW'(32'hAA);
        #1;
        chk("busy_after_fall", 128'(wr_rst_busy), 1);
        chk("rd_busy_after_fall", 128'(rd_rst_busy), 1);
        @(posedge clk);
        @(negedge clk);
        wr_en  = 1'b0;
        m_busy = 1'b0;
        chk("busy_released", 128'(wr_rst_busy), 0);
        chk("busy_write_dropped", 128'(count), 0);
        chk("busy_empty", 128'(empty), 1);

        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 32'(i), 0);
            if (i == 2) chk("pfull_at2", 128'(prog_full), 0);
            if (i == 3) chk("pfull_at3", 128'(prog_full), 1);
            if (i == 7) chk("full_at7", 128'(full), 0);
            if (i == 8) chk("full_at8", 128'(full), 1);
        end
        chk("fill_count", 128'(count), 8);
        chk("fill_full", 128'(full), 1);

        step(0, 1, 32'h77, 1);
        chk("full_rw_count", 128'(count), 7);
        chk("full_rw_notfull", 128'(full), 0);

        repeat (7) step(0, 0, 0, 1);
        chk("drain_empty", 128'(empty), 1);
        chk("drain_count", 128'(count), 0);

        step(0, 0, 0, 1);
        chk("rd_empty_valid", 128'(valid), 0);
        chk("dout_hold", 128'(dout), 8);
        chk("rd_empty_count", 128'(count), 0);

        step(0, 1, 32'h55, 1);
        chk("empty_rw_count", 128'(count), 1);
        chk("empty_rw_valid", 128'(valid), 0);
        step(0, 0, 0, 1);
        chk("empty_rw_readback", 128'(valid), 1);
        chk("empty_rw_count0", 128'(count), 0);

        step(0, 1, 32'h100, 0);
        step(0, 1, 32'h101, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 32'h200 + 32'(i), 1);
            chk("wrap_count", 128'(count), 2);
        end
        repeat (2) step(0, 0, 0, 1);
        chk("wrap_empty", 128'(empty), 1);

        for (int i = 0; i < 5; i++) step(0, 1, 32'h300 + 32'(i), 0);
        chk("mid_count5", 128'(count), 5);
        step(1, 1, 32'h3FF, 1);
        chk("mid_rst_count", 128'(count), 0);
        chk("mid_rst_empty", 128'(empty), 1);
        chk("mid_rst_valid", 128'(valid), 0);
        chk("mid_rst_busy", 128'(rd_rst_busy), 1);
        step(0, 1, 32'h3EE, 0);
        chk("mid_busy_drop", 128'(count), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h400 + 32'(i), 0);
        chk("mid_refill", 128'(count), 3);
        repeat (3) step(0, 0, 0, 1);
        chk("mid_drained", 128'(empty), 1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("err_clr_ovf", 128'(overflow), 0);
        chk("err_clr_udf", 128'(underflow), 0);
        step(0, 0, 0, 1);
        chk("udf_set", 128'(underflow), 1);
        chk("udf_no_ovf", 128'(overflow), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h500 + 32'(i), 0);
        step(0, 1, 32'h999, 0);
        chk("ovf_set", 128'(overflow), 1);
        chk("ovf_count", 128'(count), 8);
        step(0, 0, 0, 0);
        chk("ovf_sticky", 128'(overflow), 1);
        chk("udf_sticky", 128'(underflow), 1);
        repeat (8) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("ovf_rst", 128'(overflow), 0);
        chk("udf_rst", 128'(underflow), 0);
`endif

        repeat (3) step(0, 0, 0, 0);
        chk("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
